// File: rtl/ps2_scancode_decoder_if.sv
// Byte-in / key-event-out bundle between the PS/2 receiver side and the scan code decoder.
interface ps2_scancode_decoder_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_release;
    logic       key_valid;
    logic [7:0] ascii;
    logic       ascii_valid;
    logic       shift_held;
    logic       timeout_err;

    modport master (
        output rx_data, rx_valid,
        input  key_code, key_extended, key_release, key_valid,
        input  ascii, ascii_valid, shift_held, timeout_err
    );

    modport slave (
        input  rx_data, rx_valid,
        output key_code, key_extended, key_release, key_valid,
        output ascii, ascii_valid, shift_held, timeout_err
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan code set 2 parser: strips E0/F0/E1 prefixes and emits one registered key event per sequence.
// Define SUPPRESS_REPEAT_EN to drop typematic repeat makes of the most recently pressed key.
module ps2_scancode_decoder #(
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int TO_W           = 22
) (
    input  logic                   clk,
    input  logic                   reset,
    ps2_scancode_decoder_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state_q, state_d;
    logic [2:0]      pcnt_q, pcnt_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            shift_q;
    logic [7:0]      code_q, ascii_q;
    logic            ext_q, rel_q, key_valid_q, ascii_valid_q, tmo_q;

    logic            ev, ev_ext, ev_rel, tmo;
    logic [7:0]      ev_code, asc;
    logic            fake_shift, is_make, is_shift, sup, emit;

    function automatic logic [7:0] to_ascii(input logic [7:0] code, input logic shift);
        logic [7:0] c;
        case (code)
            8'h45: c = 8'h30;  8'h16: c = 8'h31;  8'h1E: c = 8'h32;  8'h26: c = 8'h33;
            8'h25: c = 8'h34;  8'h2E: c = 8'h35;  8'h36: c = 8'h36;  8'h3D: c = 8'h37;
            8'h3E: c = 8'h38;  8'h46: c = 8'h39;
            8'h29: c = 8'h20;  8'h5A: c = 8'h0D;  8'h66: c = 8'h08;
            8'h1C: c = 8'h61;  8'h32: c = 8'h62;  8'h21: c = 8'h63;  8'h23: c = 8'h64;
            8'h24: c = 8'h65;  8'h2B: c = 8'h66;  8'h34: c = 8'h67;  8'h33: c = 8'h68;
            8'h43: c = 8'h69;  8'h3B: c = 8'h6A;  8'h42: c = 8'h6B;  8'h4B: c = 8'h6C;
            8'h3A: c = 8'h6D;  8'h31: c = 8'h6E;  8'h44: c = 8'h6F;  8'h4D: c = 8'h70;
            8'h15: c = 8'h71;  8'h2D: c = 8'h72;  8'h1B: c = 8'h73;  8'h2C: c = 8'h74;
            8'h3C: c = 8'h75;  8'h2A: c = 8'h76;  8'h1D: c = 8'h77;  8'h22: c = 8'h78;
            8'h35: c = 8'h79;  8'h1A: c = 8'h7A;
            default: c = 8'h00;
        endcase
        if (shift && c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
        return c;
    endfunction

    assign fake_shift = (bus.rx_data == 8'h12) || (bus.rx_data == 8'h59);

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        cnt_d   = cnt_q;
        ev      = 1'b0;
        ev_ext  = 1'b0;
        ev_rel  = 1'b0;
        ev_code = bus.rx_data;
        tmo     = 1'b0;
        if (bus.rx_valid) begin
            // An arriving byte always beats a coincident timeout expiry.
            cnt_d = '0;
            case (state_q)
                IDLE: begin
                    case (bus.rx_data)
                        8'hE0: state_d = EXT;
                        8'hF0: state_d = BRK;
                        8'hE1: begin
                            state_d = PAUSE;
                            pcnt_d  = 3'd7;
                        end
                        8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'h00, 8'hFF: state_d = IDLE;
                        default: ev = 1'b1;
                    endcase
                end
                EXT: begin
                    if (bus.rx_data == 8'hF0) begin
                        state_d = EXT_BRK;
                    end else if (bus.rx_data != 8'hE0) begin
                        state_d = IDLE;
                        ev      = ~fake_shift;
                        ev_ext  = 1'b1;
                    end
                end
                BRK: begin
                    state_d = IDLE;
                    ev      = 1'b1;
                    ev_rel  = 1'b1;
                end
                EXT_BRK: begin
                    state_d = IDLE;
                    ev      = ~fake_shift;
                    ev_ext  = 1'b1;
                    ev_rel  = 1'b1;
                end
                PAUSE: begin
                    pcnt_d = pcnt_q - 3'd1;
                    if (pcnt_q == 3'd1) begin
                        state_d = IDLE;
                        ev      = 1'b1;
                        ev_ext  = 1'b1;
                        ev_code = 8'hE1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (cnt_q == TO_LAST) begin
                tmo     = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    assign is_make  = ev & ~ev_rel;
    assign is_shift = ~ev_ext & ((ev_code == 8'h12) | (ev_code == 8'h59));
    // Shift state is sampled before this event updates it.
    assign asc      = (is_make & ~ev_ext) ? to_ascii(ev_code, shift_q) : 8'h00;

`ifdef SUPPRESS_REPEAT_EN
    logic       last_vld_q;
    logic [8:0] last_key_q;
    logic       same_key;
    assign same_key = last_vld_q & ({ev_ext, ev_code} == last_key_q);
    assign sup      = is_make & (state_q != PAUSE) & same_key;
`else
    assign sup      = 1'b0;
`endif
    assign emit = ev & ~sup;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pcnt_q        <= '0;
            cnt_q         <= '0;
            shift_q       <= 1'b0;
            code_q        <= '0;
            ext_q         <= 1'b0;
            rel_q         <= 1'b0;
            ascii_q       <= '0;
            key_valid_q   <= 1'b0;
            ascii_valid_q <= 1'b0;
            tmo_q         <= 1'b0;
`ifdef SUPPRESS_REPEAT_EN
            last_vld_q    <= 1'b0;
            last_key_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pcnt_q        <= pcnt_d;
            cnt_q         <= cnt_d;
            key_valid_q   <= emit;
            ascii_valid_q <= emit & (asc != 8'h00);
            tmo_q         <= tmo;
            if (emit) begin
                code_q  <= ev_code;
                ext_q   <= ev_ext;
                rel_q   <= ev_rel;
                ascii_q <= asc;
            end
            if (ev & is_shift) shift_q <= ~ev_rel;
`ifdef SUPPRESS_REPEAT_EN
            if (emit & is_make & (state_q != PAUSE)) begin
                last_vld_q <= 1'b1;
                last_key_q <= {ev_ext, ev_code};
            end else if (ev & ev_rel & same_key) begin
                last_vld_q <= 1'b0;
            end
`endif
        end
    end

    assign bus.key_code     = code_q;
    assign bus.key_extended = ext_q;
    assign bus.key_release  = rel_q;
    assign bus.key_valid    = key_valid_q;
    assign bus.ascii        = ascii_q;
    assign bus.ascii_valid  = ascii_valid_q;
    assign bus.shift_held   = shift_q;
    assign bus.timeout_err  = tmo_q;
endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 controller; consumes raw received bytes plus a one-cycle receive strobe.
- Parses scan code set 2 sequences: E0 extended prefix, F0 break prefix, the 8-byte E1 Pause sequence, and keyboard status bytes.
- Emits one registered key event per complete sequence, with a registered ASCII translation for the game's bet/spin keys.
- Game logic consumes key_valid and never sees raw prefix bytes.

Parameters:
- TIMEOUT_CYCLES, 2500000, clk cycles without a byte before a partial sequence is abandoned (50 ms at 50 MHz).
- TO_W, 22, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  byte from the PS/2 controller
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle
- key_code  out  8  scan code of the event (prefixes stripped)
- key_extended  out  1  event was E0-prefixed (or Pause)
- key_release  out  1  1 = break, 0 = make
- key_valid  out  1  one-cycle event strobe
- ascii  out  8  ASCII of the event, 0 if none
- ascii_valid  out  1  one-cycle strobe, coincident with key_valid, only for translatable make events
- shift_held  out  1  level; left (12) or right (59) shift currently down
- timeout_err  out  1  one-cycle pulse when a partial sequence is abandoned

Behaviour:
- Reset clears all outputs to 0, sets state to IDLE, and clears the counters and the shift flag. Reset mid-sequence discards the partial sequence with no event.
- Latency: event outputs register on the clk edge after the rx_valid cycle that completes a sequence.
- key_code, key_extended, key_release and ascii hold their value until the next event. key_valid, ascii_valid and timeout_err are pulses.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE. Transitions occur only on rx_valid, except timeout.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE with pause_cnt=7.
  - AA, FA, EE, FC, 00 or FF -> ignored, stay in IDLE.
  - Any other byte -> make event {ext=0}, stay in IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay.
  - 12 or 59 (fake shift) -> discard, go to IDLE.
  - Any other byte -> make {ext=1}, go to IDLE.
- BRK: any byte -> break {ext=0}, go to IDLE.
- EXT_BRK:
  - 12 or 59 -> discard, go to IDLE.
  - Any other byte -> break {ext=1}, go to IDLE.
- PAUSE:
  - Each rx_valid decrements pause_cnt; bytes are not interpreted.
  - On the byte received with pause_cnt==1 -> event key_code=E1, ext=1, release=0, ascii=0, then go to IDLE.
- shift_held: set on non-extended make 12/59, cleared on non-extended break 12/59. These events still emit key_valid.
- ASCII applies only to non-extended make events:
  - Digits: 45→'0', 16→'1', 1E→'2', 26→'3', 25→'4', 2E→'5', 36→'6', 3D→'7', 3E→'8', 46→'9'.
  - 29→0x20, 5A→0x0D, 66→0x08.
  - Letters use the US set-2 map (1C a, 32 b, 21 c, 23 d, 24 e, ...). Lowercase when shift_held=0, uppercase when shift_held=1; shift_held is sampled before the update from the current event.
  - All other codes, breaks and extended events -> ascii=0, ascii_valid=0.
- Timeout:
  - The counter clears on every rx_valid and while in IDLE; otherwise it increments, saturating.
  - When the counter reaches TIMEOUT_CYCLES-1 in a non-IDLE state: go to IDLE, pulse timeout_err, no key event.
  - If rx_valid coincides with expiry, the byte wins: it is processed in the current state and no timeout occurs.
- rx_valid asserted on consecutive cycles: each byte is processed and no byte is dropped.

Optional Feature:
- Macro: SUPPRESS_REPEAT_EN.
- Defined:
  - A register holds the {ext, code} of the last emitted make.
  - A make equal to that register, with no break of that key in between (typematic repeat), produces no key_valid and no ascii_valid.
  - A break of that key clears the register. Pause is never suppressed.
- Undefined: every make, including typematic repeats, produces an event.

Test Plan:
- reset, then rx 1C -> one cycle later key_valid=1, key_code=1C, ext=0, release=0, ascii=0x61, ascii_valid=1.
- rx E0, F0, 75 -> a single key_valid with key_code=75, ext=1, release=1, ascii_valid=0; no event on the prefix bytes.
- rx 12, 1C, F0 1C, F0 12 -> events: make 12; make 1C with ascii=0x41; break 1C; break 12; shift_held ends 0.
- rx E1 14 77 E1 F0 14 F0 77 -> exactly one event, key_code=E1, ext=1; then rx 45 -> ascii=0x30.
- rx F0, then idle TIMEOUT_CYCLES cycles -> timeout_err pulse, no event; next rx 16 -> make 16, release=0, ascii=0x31.
- rx 29 three times: SUPPRESS_REPEAT_EN defined -> 1 event; undefined -> 3 events, each ascii=0x20.
